// File: rtl/tcp_checksum_patch_buffer.sv
// ============================================================================
// tcp_checksum_patch_buffer
//
// Store-and-forward stage behind the TCP encoder. A segment arrives as a
// stream of 32-bit words (pkg_data/wr_en). The encoder's checksum only becomes
// known with fin, so the segment is buffered. On replay, checksum_out is
// written into the TCP checksum field (header word 4, bits [31:16]). The
// patched segment then goes out on a valid/ready interface toward the IP/MAC
// framing stage.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         asynchronous, active-low reset
//   pkg_data      segment word from the encoder
//   wr_en         pkg_data valid this cycle
//   fin           segment complete, checksum_out valid this cycle
//   checksum_out  final TCP checksum from the encoder
//   busy          buffer is replaying and not accepting a new segment
//   out_data      patched segment word (0 when not replaying)
//   out_valid     out_data valid
//   out_ready     downstream accepts out_data
//   out_last      out_data is the final word of the segment
//   err           sticky error for the current segment; cleared when the
//                 first word of the next segment is accepted
//   seg_cnt       (TCP_SEG_CNT_EN only) count of fully drained segments,
//                 wraps at 16 bits
//
// Build option:
//   TCP_SEG_CNT_EN  adds the seg_cnt output and its counter.
// ============================================================================
module tcp_checksum_patch_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pkg_data,
    input  logic        wr_en,
    input  logic        fin,
    input  logic [15:0] checksum_out,
    output logic        busy,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
`ifdef TCP_SEG_CNT_EN
    output logic        err,
    output logic [15:0] seg_cnt
`else
    output logic        err
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // wr_cnt has one extra bit so that it can hold DEPTH itself.
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_MIN   = (ADDR_W + 1)'(5);
    localparam logic [ADDR_W-1:0] PATCH_IDX = ADDR_W'(4);

    logic [1:0]        state;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       csum_q;
    logic              err_q;

    logic              has_room;
    logic              fill_wr;
    logic [ADDR_W:0]   fill_total;
    logic              at_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       rd_word;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_comb begin
        has_room = (wr_cnt < CNT_FULL);
        fill_wr  = (state == S_FILL) && wr_en && has_room;
        // A word arriving together with fin is counted before the
        // minimum-length decision is made.
        fill_total = wr_cnt + (fill_wr ? CNT_ONE : '0);
        mem_we     = ((state == S_IDLE) && wr_en) || fill_wr;
        mem_waddr  = (state == S_IDLE) ? '0 : wr_cnt[ADDR_W-1:0];
    end

    // Storage carries no reset; its content is only visible while
    // replaying, and every replayed location was written by the segment.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= pkg_data;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = mem[rd_ptr];
        at_last = ({1'b0, rd_ptr} == (wr_cnt - CNT_ONE));
    end

    // Outputs are decoded from state so that reset clears them
    // asynchronously and a stalled word stays stable without extra
    // holding registers.
    always_comb begin
        busy      = (state == S_DRAIN);
        out_valid = (state == S_DRAIN);
        out_last  = (state == S_DRAIN) && at_last;
        err       = err_q;
        out_data  = '0;
        if (state == S_DRAIN) begin
            if (rd_ptr == PATCH_IDX) begin
                // Checksum replaces the upper half; the urgent pointer stays.
                out_data = {csum_q, rd_word[15:0]};
            end else begin
                out_data = rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
`ifdef TCP_SEG_CNT_EN
            seg_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en) begin
                        if (fin) begin
                            // One-word segment: below the minimum length,
                            // so it is discarded right away.
                            err_q  <= 1'b1;
                            wr_cnt <= '0;
                        end else begin
                            err_q  <= 1'b0;
                            wr_cnt <= CNT_ONE;
                            state  <= S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (wr_en) begin
                        if (has_room) begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (fin) begin
                        csum_q <= checksum_out;
                        if (fill_total >= CNT_MIN) begin
                            state <= S_DRAIN;
                        end else begin
                            err_q  <= 1'b1;
                            wr_cnt <= '0;
                            state  <= S_IDLE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (wr_en || fin) begin
                        err_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (at_last) begin
                            rd_ptr <= '0;
                            wr_cnt <= '0;
                            state  <= S_IDLE;
`ifdef TCP_SEG_CNT_EN
                            seg_cnt <= seg_cnt + 16'd1;
`endif
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    wr_cnt <= '0;
                    rd_ptr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_checksum_patch_buffer.sv
module tb_tcp_checksum_patch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pkg_data;
    logic        wr_en;
    logic        fin;
    logic [15:0] checksum_out;
    logic        busy;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err;
`ifdef TCP_SEG_CNT_EN
    logic [15:0] seg_cnt;
`endif

    always #5 clk = ~clk;

    tcp_checksum_patch_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .pkg_data     (pkg_data),
        .wr_en        (wr_en),
        .fin          (fin),
        .checksum_out (checksum_out),
        .busy         (busy),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
`ifdef TCP_SEG_CNT_EN
        .err          (err),
        .seg_cnt      (seg_cnt)
`else
        .err          (err)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] tx[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          unstable;
    bit          timeout;
    logic        pre_fin_valid;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected replay word i: the input word, with the checksum at word 4.
    function automatic logic [31:0] exp_word(input int i, input logic [15:0] cs);
        logic [31:0] w;
        w = tx[i];
        if (i == 4) w = {cs, w[15:0]};
        return w;
    endfunction

    task automatic send_seg(input bit fin_after, input logic [15:0] cs);
        checksum_out = cs;
        for (int i = 0; i < tx.size(); i++) begin
            wr_en    = 1'b1;
            pkg_data = tx[i];
            fin      = (!fin_after && i == tx.size() - 1);
            if (fin) pre_fin_valid = out_valid;
            step();
        end
        wr_en    = 1'b0;
        pkg_data = '0;
        fin      = 1'b0;
        if (fin_after) begin
            fin = 1'b1;
            pre_fin_valid = out_valid;
            step();
            fin = 1'b0;
        end
    endtask

    // Receives a segment; stalls 3 cycles before accepting indices sa and sb.
    task automatic collect(input int sa, input int sb, input int budget);
        logic [31:0] sd;
        logic        sl;
        int          stalls;
        int          n;
        int          idx;
        got_d.delete();
        got_l.delete();
        unstable = 0;
        timeout  = 1'b0;
        stalls   = 0;
        sd       = '0;
        sl       = 1'b0;
        n        = 0;
        while (n < budget && !(!out_valid && got_d.size() > 0)) begin
            if (out_valid) begin
                idx = got_d.size();
                if ((idx == sa || idx == sb) && stalls < 3) begin
                    out_ready = 1'b0;
                    if (stalls == 0) begin
                        sd = out_data;
                        sl = out_last;
                    end else if (out_data !== sd || out_last !== sl) begin
                        unstable++;
                    end
                    stalls++;
                end else begin
                    if (stalls > 0 && (out_data !== sd || out_last !== sl)) unstable++;
                    out_ready = 1'b1;
                    got_d.push_back(out_data);
                    got_l.push_back(out_last);
                    stalls = 0;
                end
            end else begin
                out_ready = 1'b0;
            end
            step();
            n++;
        end
        if (n >= budget) timeout = 1'b1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        fin = 1'b0;
        pkg_data = '0;
        checksum_out = '0;
        out_ready = 1'b0;
        repeat (3) step();
        total++;
        if ({busy, out_valid, out_last, err, out_data} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b valid=%b last=%b err=%b data=%h, want all 0",
                     busy, out_valid, out_last, err, out_data);
        end
`ifdef TCP_SEG_CNT_EN
        total++;
        if (seg_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_seg_cnt: got %h want 0000", seg_cnt);
        end
`endif
        reset = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_minimal();
        logic [15:0] cs;
        int n;
        cs = 16'hBEEF;
        tx = '{32'hA08F2694, 32'h00000001, 32'h00000002, 32'h503F0003, 32'h00000004};
        n = 5;
        send_seg(1'b0, cs);
        total++;
        if (pre_fin_valid !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL min_latency: got pre_fin_valid=%b valid=%b busy=%b want 0 1 1",
                     pre_fin_valid, out_valid, busy);
        end
        collect(-1, -1, 100);
        total++;
        if (timeout || got_d.size() != n) begin
            bad++;
            $display("FAIL min_count: got words=%0d timeout=%b want %0d 0", got_d.size(), timeout, n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_word(i, cs) || got_l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL min_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, got_d[i], got_l[i], exp_word(i, cs), (i == n - 1));
            end
        end
        total++;
        if (got_d.size() > 4 && got_d[4] !== 32'hBEEF0004) begin
            bad++;
            $display("FAIL min_patch: got %h want beef0004", got_d[4]);
        end
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL min_idle: got busy=%b valid=%b err=%b want 0 0 0", busy, out_valid, err);
        end
`ifdef TCP_SEG_CNT_EN
        total++;
        if (seg_cnt !== 16'd1) begin
            bad++;
            $display("FAIL min_seg_cnt: got %0d want 1", seg_cnt);
        end
`endif
    endtask

    task automatic test_payload();
        logic [15:0] cs;
        int n;
        cs = 16'h5A5A;
        tx = '{32'h1F900050, 32'h00001000, 32'h00002000, 32'hA018FFFF, 32'h12340000,
               32'h020405B4, 32'h0101080A, 32'h00001111, 32'h00002222, 32'h01010103,
               32'h48656C6C, 32'h6F20576F, 32'h726C6400};
        n = 13;
        send_seg(1'b1, cs);
        total++;
        if (pre_fin_valid !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pay_latency: got pre_fin_valid=%b valid=%b want 0 1", pre_fin_valid, out_valid);
        end
        collect(-1, -1, 100);
        total++;
        if (timeout || got_d.size() != n) begin
            bad++;
            $display("FAIL pay_count: got words=%0d timeout=%b want %0d 0", got_d.size(), timeout, n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_word(i, cs) || got_l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL pay_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, got_d[i], got_l[i], exp_word(i, cs), (i == n - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] cs;
        int n;
        cs = 16'hC0DE;
        tx = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'h5555AAAA, 32'h66666666, 32'h77777777, 32'h88888888};
        n = 8;
        send_seg(1'b0, cs);
        collect(2, n - 1, 100);
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_stable: got %0d unstable stall cycles want 0", unstable);
        end
        total++;
        if (timeout || got_d.size() != n) begin
            bad++;
            $display("FAIL bp_count: got words=%0d timeout=%b want %0d 0", got_d.size(), timeout, n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_word(i, cs) || got_l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL bp_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, got_d[i], got_l[i], exp_word(i, cs), (i == n - 1));
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] cs;
        int n;
        cs = 16'h0F0F;
        tx.delete();
        for (int i = 0; i < 70; i++) tx.push_back(32'h10000000 + i);
        n = 64;
        send_seg(1'b1, cs);
        total++;
        if (err !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_err: got err=%b valid=%b want 1 1", err, out_valid);
        end
        collect(-1, -1, 300);
        total++;
        if (timeout || got_d.size() != n) begin
            bad++;
            $display("FAIL ovf_count: got words=%0d timeout=%b want %0d 0", got_d.size(), timeout, n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_word(i, cs) || got_l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL ovf_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, got_d[i], got_l[i], exp_word(i, cs), (i == n - 1));
            end
        end
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_after: got err=%b busy=%b want 1 0", err, busy);
        end
    endtask

    task automatic test_short_and_busy();
        logic [15:0] cs;
        int n;
`ifdef TCP_SEG_CNT_EN
        logic [15:0] cnt0;
        cnt0 = seg_cnt;
`endif
        // A: three-word segment is rejected
        tx = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
        send_seg(1'b0, 16'h1234);
        total++;
        if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL short_abort: got err=%b valid=%b busy=%b want 1 0 0", err, out_valid, busy);
        end
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL short_quiet: got valid=%b err=%b want 0 1", out_valid, err);
        end
`ifdef TCP_SEG_CNT_EN
        total++;
        if (seg_cnt !== cnt0) begin
            bad++;
            $display("FAIL short_seg_cnt: got %0d want %0d", seg_cnt, cnt0);
        end
`endif
        // B: writes during replay are dropped
        cs = 16'h7777;
        tx = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
        n = 5;
        send_seg(1'b0, cs);
        total++;
        if (err !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL busy_errclr: got err=%b valid=%b want 0 1", err, out_valid);
        end
        wr_en = 1'b1;
        pkg_data = 32'hFFFF_FFFF;
        step();
        wr_en = 1'b0;
        pkg_data = '0;
        total++;
        if (err !== 1'b1 || out_data !== tx[0] || busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_drop: got err=%b data=%h busy=%b want 1 %h 1", err, out_data, busy, tx[0]);
        end
        collect(-1, -1, 100);
        total++;
        if (timeout || got_d.size() != n) begin
            bad++;
            $display("FAIL busy_count: got words=%0d timeout=%b want %0d 0", got_d.size(), timeout, n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_word(i, cs) || got_l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL busy_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, got_d[i], got_l[i], exp_word(i, cs), (i == n - 1));
            end
        end
`ifdef TCP_SEG_CNT_EN
        total++;
        if (seg_cnt !== cnt0 + 16'd1) begin
            bad++;
            $display("FAIL busy_seg_cnt: got %0d want %0d", seg_cnt, cnt0 + 16'd1);
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        logic [15:0] cs;
        int n;
        tx = '{32'h0A0A0000, 32'h0A0A0001, 32'h0A0A0002, 32'h0A0A0003, 32'h0A0A0004, 32'h0A0A0005};
        send_seg(1'b0, 16'h9999);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        total++;
        if (out_data !== tx[3] || out_valid !== 1'b1 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL rst_pre: got data=%h valid=%b last=%b want %h 1 0", out_data, out_valid, out_last, tx[3]);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, out_last, err, out_data} !== 36'h0) begin
            bad++;
            $display("FAIL rst_async: got busy=%b valid=%b last=%b err=%b data=%h, want all 0",
                     busy, out_valid, out_last, err, out_data);
        end
`ifdef TCP_SEG_CNT_EN
        total++;
        if (seg_cnt !== 16'h0) begin
            bad++;
            $display("FAIL rst_seg_cnt: got %0d want 0", seg_cnt);
        end
`endif
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_noreplay: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
        cs = 16'h4242;
        tx = '{32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB000ABCD};
        n = 5;
        send_seg(1'b0, cs);
        collect(-1, -1, 100);
        total++;
        if (timeout || got_d.size() != n) begin
            bad++;
            $display("FAIL rst_count: got words=%0d timeout=%b want %0d 0", got_d.size(), timeout, n);
        end
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_word(i, cs) || got_l[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL rst_word%0d: got data=%h last=%b want data=%h last=%b",
                         i, got_d[i], got_l[i], exp_word(i, cs), (i == n - 1));
            end
        end
`ifdef TCP_SEG_CNT_EN
        total++;
        if (seg_cnt !== 16'd1) begin
            bad++;
            $display("FAIL rst_seg_cnt_after: got %0d want 1", seg_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_minimal();
        test_payload();
        test_backpressure();
        test_overflow();
        test_short_and_busy();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcp_checksum_patch_buffer.md
Name: tcp_checksum_patch_buffer

Overview:
- Store-and-forward stage directly downstream of TCP_encoder.
- Captures the 32-bit segment word stream (pkg_data/wr_en) until fin, then inserts the final checksum_out into the TCP checksum field (header word 4, bits [31:16]).
- Replays the patched segment on a valid/ready output toward the IP/MAC framing stage.
- Needed because the encoder's checksum is only known after the last word has been emitted.

Parameters:
- DEPTH, 64, maximum segment length in 32-bit words (header + options + payload).
- ADDR_W, 6, pointer width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- pkg_data  input  32  segment word from the encoder.
- wr_en  input  1  pkg_data is valid this cycle.
- fin  input  1  segment complete; checksum_out valid this cycle.
- checksum_out  input  16  final TCP checksum from the encoder.
- busy  output  1  buffer not accepting a new segment (DRAIN state).
- out_data  output  32  patched segment word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  current out_data is the final word of the segment.
- err  output  1  sticky error for the current segment; cleared on the next accepted word in IDLE.

Behaviour:
- Reset values: busy=0, out_valid=0, out_last=0, out_data=0, err=0. State is IDLE, and wr_cnt, rd_ptr and the stored checksum are 0.
- FSM states: IDLE, FILL, DRAIN.
- IDLE:
  - wr_en stores pkg_data at address 0, sets wr_cnt=1, clears err, and moves to FILL.
  - fin without any word is ignored.
- FILL:
  - Each wr_en writes mem[wr_cnt] and increments wr_cnt.
  - wr_en while wr_cnt==DEPTH drops the word and sets err.
  - fin may coincide with the final wr_en; that word is stored first, then fin is evaluated.
  - On fin, checksum_out is latched into csum_q.
  - If the word count including a coincident word is >=5, go to DRAIN.
  - If it is <5, set err, discard the segment and return to IDLE.
- DRAIN:
  - busy=1 and out_valid=1 from the cycle after fin. Latency from fin to first out_valid is 1 clk.
  - out_data = mem[rd_ptr], except at rd_ptr==4, where it is {csum_q, mem[4][15:0]} (urgent pointer preserved).
  - out_last = (rd_ptr==wr_cnt-1).
  - A word transfers when out_valid && out_ready; rd_ptr then increments.
  - out_ready low holds out_data, out_valid and out_last stable.
  - On transfer of the last word, go to IDLE next cycle, reset rd_ptr and wr_cnt to 0, and drop busy and out_valid.
  - wr_en or fin arriving in DRAIN is dropped and sets err. err stays visible until the next segment starts.
- err never blocks draining of a valid segment (overflow still drains DEPTH words).
- out_data in IDLE/FILL is 0.
- Asserting reset mid-FILL or mid-DRAIN discards the segment. All outputs take their reset values asynchronously, and no partial segment is replayed after release.
- Back-to-back operation: a new segment may start with wr_en in the first IDLE cycle after the last drain transfer.

Optional Feature:
- TCP_SEG_CNT_EN defined:
  - Adds output port seg_cnt [15:0].
  - seg_cnt increments by 1 on each completed drain (last-word transfer) and wraps 0xFFFF -> 0x0000.
  - Reset value is 0.
  - Segments aborted by the <5-word rule or by reset are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Minimal segment:
   - Stimulus: 5 header words 0xA08F2694, 0x00000001, 0x00000002, 0x503F0003, 0x00000004, with fin on the 5th word and checksum_out=0xBEEF.
   - Expected: 5 output words, word 4 = 0xBEEF0004, out_last only on word 4, first out_valid 1 clk after fin.
2. Header + options + 11-byte payload ("Hello World", 3 data words, last padded 0x726C6400), 13 words total, with fin one cycle after the last wr_en.
   - Expected: all 13 words replayed in order, only word 4 patched.
3. Backpressure: hold out_ready low for 3 cycles at rd_ptr=2 and again at the last word.
   - Expected: out_data, out_valid and out_last stable; no duplicated or skipped words.
4. Overflow: 70 wr_en words, then fin.
   - Expected: err=1; 64 words drained; words 65-70 are absent from the output.
5. Short segment and busy drop:
   - Stimulus A: fin after 3 words. Expected: err=1, no out_valid, state back to IDLE.
   - Stimulus B: wr_en during DRAIN. Expected: word dropped, err=1, drained data unchanged.
6. Reset and counter:
   - Stimulus: drive reset low mid-DRAIN at rd_ptr=3.
   - Expected: outputs cleared immediately; the next segment drains correctly from word 0.
   - With TCP_SEG_CNT_EN: seg_cnt=1 after test 1; it does not increment for the aborted segment.
